// File: rtl/tetris_seq_ctrl.sv
// rtl/tetris_seq_ctrl.sv - falling-block game sequencer: gravity tick, collision checks, lock, row clear
// Sequences check/command handshakes against an external grid datapath and scans for full rows after lock.
module tetris_seq_ctrl #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int TICK_DIV = 32768
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ctrl1,
    input  logic            ctrl2,
    output logic            chk_req,
    output logic [1:0]      chk_op,
    input  logic            chk_ack,
    input  logic            chk_hit,
    output logic            cmd_valid,
    output logic [2:0]      cmd_op,
    output logic [3:0]      cmd_row,
    input  logic            cmd_ready,
    output logic [3:0]      row_addr,
    input  logic [COLS-1:0] row_data,
    output logic [7:0]      lines_cleared,
    output logic            game_over
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0]    LAST_ROW = 4'(ROWS - 1);

    localparam logic [1:0] CK_SPAWN = 2'd0, CK_LEFT = 2'd1, CK_RIGHT = 2'd2, CK_DOWN = 2'd3;
    localparam logic [2:0] OP_SPAWN = 3'd0, OP_DOWN = 3'd3, OP_LOCK = 3'd4, OP_CLEAR = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_SPAWN_CHK, S_SPAWN_CMD, S_WAIT_TICK, S_MOVE_CHK, S_MOVE_CMD,
        S_FALL_CHK, S_FALL_CMD, S_LOCK, S_SCAN, S_CLEAR, S_OVER
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pend_q, pend_d;
    logic           chk_req_q, chk_req_d;
    logic [1:0]     chk_op_q, chk_op_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic [2:0]     cmd_op_q, cmd_op_d;
    logic [3:0]     cmd_row_q, cmd_row_d;
    logic [3:0]     row_addr_q, row_addr_d;
    logic [7:0]     lines_q, lines_d;
    logic           over_q, over_d;
    logic [1:0]     move_op_q, move_op_d;
    logic           phase_q, phase_d;
    logic           tick;

    // Each *_CHK / *_CMD state raises its own request on entry, so a request
    // always drops for at least one cycle between consecutive transactions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        chk_req_d   = chk_req_q;
        chk_op_d    = chk_op_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_row_d   = cmd_row_q;
        row_addr_d  = row_addr_q;
        lines_d     = lines_q;
        over_d      = over_q;
        move_op_d   = move_op_q;
        phase_d     = phase_q;

        tick = (state_q != S_OVER) && (cnt_q == CNT_LAST);
        if (state_q != S_OVER) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: state_d = S_SPAWN_CHK;
            S_SPAWN_CHK: begin
                if (!chk_req_q) begin
                    chk_req_d = 1'b1;
                    chk_op_d  = CK_SPAWN;
                end else if (chk_ack) begin
                    chk_req_d = 1'b0;
                    over_d    = chk_hit;
                    state_d   = chk_hit ? S_OVER : S_SPAWN_CMD;
                end
            end
            S_SPAWN_CMD: begin
                if (!cmd_valid_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_SPAWN;
                end else if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_WAIT_TICK;
                end
            end
            S_WAIT_TICK: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (ctrl1 ^ ctrl2) begin
                        move_op_d = ctrl1 ? CK_LEFT : CK_RIGHT;
                        state_d   = S_MOVE_CHK;
                    end else begin
                        state_d = S_FALL_CHK;
                    end
                end
            end
            S_MOVE_CHK: begin
                if (!chk_req_q) begin
                    chk_req_d = 1'b1;
                    chk_op_d  = move_op_q;
                end else if (chk_ack) begin
                    chk_req_d = 1'b0;
                    state_d   = chk_hit ? S_FALL_CHK : S_MOVE_CMD;
                end
            end
            S_MOVE_CMD: begin
                if (!cmd_valid_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = {1'b0, move_op_q};
                end else if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_FALL_CHK;
                end
            end
            S_FALL_CHK: begin
                if (!chk_req_q) begin
                    chk_req_d = 1'b1;
                    chk_op_d  = CK_DOWN;
                end else if (chk_ack) begin
                    chk_req_d = 1'b0;
                    state_d   = chk_hit ? S_LOCK : S_FALL_CMD;
                end
            end
            S_FALL_CMD: begin
                if (!cmd_valid_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_DOWN;
                end else if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_WAIT_TICK;
                end
            end
            S_LOCK: begin
                if (!cmd_valid_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_LOCK;
                end else if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    row_addr_d  = LAST_ROW;
                    phase_d     = 1'b0;
                    state_d     = S_SCAN;
                end
            end
            // phase 0 presents the address, phase 1 sees the registered row contents
            S_SCAN: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (&row_data) begin
                        state_d = S_CLEAR;
                    end else if (row_addr_q == 4'd0) begin
                        state_d = S_SPAWN_CHK;
                    end else begin
                        row_addr_d = row_addr_q - 4'd1;
                    end
                end
            end
            S_CLEAR: begin
                if (!cmd_valid_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_CLEAR;
                    cmd_row_d   = row_addr_q;
                end else if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    if (lines_q != 8'hFF) lines_d = lines_q + 8'd1;
                    state_d = S_SCAN;
                end
            end
            S_OVER: begin
                chk_req_d   = 1'b0;
                cmd_valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (tick) pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            chk_req_q   <= 1'b0;
            chk_op_q    <= 2'd0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= 3'd0;
            cmd_row_q   <= 4'd0;
            row_addr_q  <= LAST_ROW;
            lines_q     <= 8'd0;
            over_q      <= 1'b0;
            move_op_q   <= 2'd0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            chk_req_q   <= chk_req_d;
            chk_op_q    <= chk_op_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_row_q   <= cmd_row_d;
            row_addr_q  <= row_addr_d;
            lines_q     <= lines_d;
            over_q      <= over_d;
            move_op_q   <= move_op_d;
            phase_q     <= phase_d;
        end
    end

    assign chk_req       = chk_req_q;
    assign chk_op        = chk_op_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_op        = cmd_op_q;
    assign cmd_row       = cmd_row_q;
    assign row_addr      = row_addr_q;
    assign lines_cleared = lines_q;
    assign game_over     = over_q;
endmodule

// File: tb/tb_tetris_seq_ctrl.sv
// tb/tb_tetris_seq_ctrl.sv - scoreboard bench for tetris_seq_ctrl with a behavioural grid datapath
module tb_tetris_seq_ctrl;
    localparam int TD = 16;

    logic        clk = 1'b0;
    logic        rst_n, ctrl1, ctrl2, chk_ack, cmd_ready;
    logic        chk_req, cmd_valid, game_over;
    logic [1:0]  chk_op;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_row, row_addr;
    logic [15:0] row_data;
    logic [7:0]  lines_cleared;
    logic        chk_hit;
    logic        hit_spawn, hit_move, hit_down;

    logic [15:0] grid [16];
    int          refill;
    logic [6:0]  exp_q [$];
    int          down_t [$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          ref_t;

    tetris_seq_ctrl #(.ROWS(16), .COLS(16), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(rst_n), .ctrl1(ctrl1), .ctrl2(ctrl2),
        .chk_req(chk_req), .chk_op(chk_op), .chk_ack(chk_ack), .chk_hit(chk_hit),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_ready(cmd_ready),
        .row_addr(row_addr), .row_data(row_data),
        .lines_cleared(lines_cleared), .game_over(game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) row_data <= grid[row_addr];

    assign chk_hit = chk_req && (((chk_op == 2'd0) && hit_spawn) ||
                                 ((chk_op == 2'd3) && hit_down)  ||
                                 ((chk_op == 2'd1 || chk_op == 2'd2) && hit_move));

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [3:0] row);
        exp_q.push_back({op, row});
    endtask

    // Pops one expected command per accepted transfer; CLEAR_ROW also shifts the grid model.
    task automatic monitor();
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", {29'd0, cmd_op}, 32'd99);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_op", {29'd0, cmd_op}, {29'd0, e[6:4]});
                    if (e[6:4] == 3'd5) check("cmd_row", {28'd0, cmd_row}, {28'd0, e[3:0]});
                end
                if (cmd_op == 3'd3) down_t.push_back(cyc);
                if (cmd_op == 3'd5) begin
                    for (int r = 15; r > 0; r--) if (r <= int'(cmd_row)) grid[r] = grid[r-1];
                    grid[0] = (refill > 0) ? 16'hFFFF : 16'h0000;
                    if (refill > 0) refill--;
                end
            end
        end
    endtask

    task automatic drain(input int maxc, input string nm);
        int k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(nm, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (!cmd_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check(nm, {31'd0, cmd_valid}, 1);
    endtask

    initial begin
        int bad;
        rst_n = 0; ctrl1 = 0; ctrl2 = 0; chk_ack = 1; cmd_ready = 1;
        hit_spawn = 0; hit_move = 0; hit_down = 0; refill = 0;
        for (int r = 0; r < 16; r++) grid[r] = 16'h0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_chk_req", {31'd0, chk_req}, 0);
        check("rst_cmd_valid", {31'd0, cmd_valid}, 0);
        check("rst_chk_op", {30'd0, chk_op}, 0);
        check("rst_cmd_op", {29'd0, cmd_op}, 0);
        check("rst_cmd_row", {28'd0, cmd_row}, 0);
        check("rst_row_addr", {28'd0, row_addr}, 15);
        check("rst_lines", {24'd0, lines_cleared}, 0);
        check("rst_game_over", {31'd0, game_over}, 0);

        // idle falling: SPAWN then one DOWN per tick period
        push(3'd0, 0); push(3'd3, 0); push(3'd3, 0); push(3'd3, 0);
        rst_n = 1;
        drain(120, "drain_spawn_fall");
        if (down_t.size() >= 3) begin
            check("down_period_a", down_t[1] - down_t[0], TD);
            check("down_period_b", down_t[2] - down_t[1], TD);
        end else check("down_count", down_t.size(), 3);
        ref_t = (down_t.size() > 0) ? down_t[down_t.size()-1] : 0;

        ctrl1 = 1; push(3'd1, 0); push(3'd3, 0);
        drain(40, "drain_left");
        ctrl1 = 1; ctrl2 = 1; push(3'd3, 0);
        drain(40, "drain_both");
        ctrl1 = 0; ctrl2 = 1; push(3'd2, 0); push(3'd3, 0);
        drain(40, "drain_right");
        ctrl2 = 0; ctrl1 = 1; hit_move = 1; push(3'd3, 0);
        drain(40, "drain_move_blocked");
        ctrl1 = 0; hit_move = 0;
        down_t.delete();

        // stall a DOWN for 50+ cycles, release aligned to the normal DOWN slot
        cmd_ready = 0;
        wait_valid("stall_valid");
        bad = 0;
        for (int k = 0; k < 80 && (k < 50 || ((cyc - ref_t) % TD) != 0); k++) begin
            @(posedge clk); #1;
            if (!(cmd_valid && cmd_op == 3'd3)) bad++;
        end
        check("stall_stable", bad, 0);
        push(3'd3, 0); push(3'd3, 0); push(3'd3, 0);
        cmd_ready = 1;
        drain(60, "drain_stall");
        if (down_t.size() >= 3) begin
            check("pending_serviced", down_t[1] - down_t[0], 5);
            check("pending_single", down_t[2] - down_t[1], 11);
        end else check("stall_down_count", down_t.size(), 3);

        // lock with rows 15 and 14 full
        grid[15] = 16'hFFFF; grid[14] = 16'hFFFF; grid[13] = 16'h7FFF;
        hit_down = 1;
        push(3'd4, 0); push(3'd5, 15); push(3'd5, 15); push(3'd0, 0);
        drain(300, "drain_lock_clear");
        hit_down = 0;
        check("lines_two", {24'd0, lines_cleared}, 2);

        // 255 more full rows: counter saturates
        for (int r = 0; r < 16; r++) grid[r] = 16'hFFFF;
        refill = 239;
        hit_down = 1;
        push(3'd4, 0);
        for (int i = 0; i < 255; i++) push(3'd5, 15);
        push(3'd0, 0);
        drain(3000, "drain_saturate");
        hit_down = 0;
        check("lines_sat", {24'd0, lines_cleared}, 255);

        // reset mid-command, then a blocked spawn
        cmd_ready = 0;
        wait_valid("pre_reset_valid");
        rst_n = 0;
        #1;
        check("midrst_cmd_valid", {31'd0, cmd_valid}, 0);
        check("midrst_lines", {24'd0, lines_cleared}, 0);
        hit_spawn = 1; cmd_ready = 1;
        @(posedge clk); #1;
        rst_n = 1;
        bad = 0;
        for (int k = 0; k < 20 && !game_over; k++) begin
            @(posedge clk); #1;
        end
        check("game_over_set", {31'd0, game_over}, 1);
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); #1;
            if (cmd_valid || chk_req || !game_over) bad++;
        end
        check("over_quiet", bad, 0);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("over_reset_async", {31'd0, game_over}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tetris_seq_ctrl.md
TETRIS_SEQ_CTRL -- requirements
Module: tetris_seq_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 16, grid row count (row 0 = top).
REQ-002 SHALL have parameter COLS, default 16, grid column count and row_data width.
REQ-003 SHALL have parameter TICK_DIV, default 32768, clk cycles per gravity tick.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ctrl1  input  1  move-left request, level-sampled.
REQ-007 SHALL have port ctrl2  input  1  move-right request, level-sampled.
REQ-008 SHALL have port chk_req  output  1  collision-check request to the grid datapath.
REQ-009 SHALL have port chk_op  output  2  check type: 0 SPAWN, 1 LEFT, 2 RIGHT, 3 DOWN.
REQ-010 SHALL have port chk_ack  input  1  check complete.
REQ-011 SHALL have port chk_hit  input  1  collision result, valid only while chk_ack=1.
REQ-012 SHALL have port cmd_valid  output  1  datapath command valid.
REQ-013 SHALL have port cmd_op  output  3  command: 0 SPAWN, 1 LEFT, 2 RIGHT, 3 DOWN, 4 LOCK, 5 CLEAR_ROW.
REQ-014 SHALL have port cmd_row  output  4  target row for CLEAR_ROW.
REQ-015 SHALL have port cmd_ready  input  1  datapath accepts command.
REQ-016 SHALL have port row_addr  output  4  grid row read address.
REQ-017 SHALL have port row_data  input  COLS  row contents, valid one cycle after row_addr.
REQ-018 SHALL have port lines_cleared  output  8  total rows cleared, saturating.
REQ-019 SHALL have port game_over  output  1  spawn blocked; sticky.

Function
REQ-020 SHALL implement states IDLE, SPAWN_CHK, SPAWN_CMD, WAIT_TICK, MOVE_CHK, MOVE_CMD, FALL_CHK, FALL_CMD, LOCK, SCAN, CLEAR, OVER.
REQ-021 SHALL run a free counter 0..TICK_DIV-1 with a one-cycle tick pulse at wrap, in every state except OVER.
REQ-022 SHALL set a single pending-tick flag on tick; flag cleared when WAIT_TICK consumes it; extra ticks while pending are dropped.
REQ-023 SHALL leave IDLE for SPAWN_CHK the cycle after reset deasserts.
REQ-024 Check handshake SHALL hold chk_req=1 with stable chk_op until the cycle chk_ack=1, sample chk_hit that cycle, deassert chk_req the next cycle.
REQ-025 Command handshake SHALL hold cmd_valid=1 with stable cmd_op/cmd_row until cmd_valid&cmd_ready; transfer in that cycle; cmd_valid low the next cycle.
REQ-026 SPAWN_CHK: hit -> OVER; no hit -> SPAWN_CMD (op SPAWN) -> WAIT_TICK.
REQ-027 WAIT_TICK with pending tick: sample ctrl1/ctrl2; exactly one set -> MOVE_CHK (LEFT if ctrl1, RIGHT if ctrl2); both or neither -> FALL_CHK.
REQ-028 MOVE_CHK: hit -> FALL_CHK (move discarded); no hit -> MOVE_CMD with same op -> FALL_CHK.
REQ-029 FALL_CHK (op DOWN): no hit -> FALL_CMD (op DOWN) -> WAIT_TICK; hit -> LOCK.
REQ-030 LOCK SHALL issue cmd LOCK, then enter SCAN with row_addr=ROWS-1.
REQ-031 SCAN SHALL present row_addr, wait one cycle, test row_data all-ones: full -> CLEAR; else if row_addr=0 -> SPAWN_CHK, else decrement row_addr and repeat.
REQ-032 CLEAR SHALL issue CLEAR_ROW with cmd_row=row_addr, increment lines_cleared (saturate at 255), return to SCAN at the same row_addr (rows above shift down).
REQ-033 OVER SHALL set game_over=1, hold all request outputs low, ignore all inputs until reset.
REQ-034 ctrl1/ctrl2 SHALL be ignored outside the WAIT_TICK tick-consume cycle.
REQ-035 chk_ack or cmd_ready asserted while no request is outstanding SHALL be ignored.

Reset
REQ-036 reset low SHALL asynchronously force state IDLE, tick counter 0, pending flag 0, chk_req 0, cmd_valid 0, chk_op 0, cmd_op 0, cmd_row 0, row_addr ROWS-1, lines_cleared 0, game_over 0.
REQ-037 reset asserted mid-handshake SHALL abandon the transaction; no command is reissued after release except the normal SPAWN sequence.

Verification
REQ-038 Empty grid, chk_hit=0, ready/ack tied high, no buttons -> SPAWN then one DOWN command per TICK_DIV cycles.
REQ-039 ctrl1=1 at tick, LEFT check no hit -> LEFT command then DOWN command, same tick; ctrl1=ctrl2=1 -> DOWN only.
REQ-040 DOWN check hit -> LOCK; rows 15 and 14 all-ones, 13 not -> CLEAR_ROW 15 twice (rescan), lines_cleared +2, then scan continues to row 0, then SPAWN_CHK.
REQ-041 SPAWN check hit -> game_over=1 next cycle, cmd_valid/chk_req stay 0 for 1000 cycles; reset low -> game_over 0 immediately.
REQ-042 cmd_ready held low 50 cycles with DOWN pending -> cmd_valid/cmd_op stable throughout; two ticks elapse -> only one pending tick serviced.
REQ-043 lines_cleared at 255 plus one more clear -> stays 255.
